// File: rtl/hatch_fetch_ctrl.sv
// Instruction-fetch sequencer: issues 6-byte-stride fetches under a credit limit,
// buffers returned words in a prefetch queue and discards responses made stale by redirects.
module hatch_fetch_ctrl #(
    parameter int          DEPTH      = 4,
    parameter int          INSN_BYTES = 6,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [47:0] mem_rsp_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [47:0] ins_data,
    output logic [31:0] ins_addr,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight, queued, drop;
    logic [CW-1:0] inflight_nxt, queued_nxt, drop_nxt;
    logic [CW:0]   credit_used;
    logic [PW-1:0] af_wr, af_rd, q_wr, q_rd;
    logic [31:0]   af_mem [DEPTH];
    logic [31:0]   q_addr [DEPTH];
    logic [47:0]   q_data [DEPTH];
    logic          acc, rsp, push, pop;

    assign credit_used = {1'b0, queued} + {1'b0, inflight};
    assign acc         = mem_req_valid && mem_req_ready;
    assign rsp         = mem_rsp_valid;
    // A response landing in the redirect cycle is stale as well, so it never enters the queue.
    assign push        = rsp && (drop == '0) && !redirect_valid;
    assign pop         = ins_valid && ins_ready;

    assign mem_req_addr = fetch_pc;
    assign ins_valid    = (queued != '0);
    assign ins_data     = ins_valid ? q_data[q_rd] : 48'h0;
    assign ins_addr     = ins_valid ? q_addr[q_rd] : 32'h0;

    always_comb begin
        inflight_nxt  = inflight + CW'(acc) - CW'(rsp);
        queued_nxt    = queued + CW'(push) - CW'(pop);
        drop_nxt      = drop;
        state_nxt     = state;
        mem_req_valid = !rst && (state == RUN) && !halt && !redirect_valid
                        && (credit_used < DEPTH_C);
        busy          = (state != RUN) || (inflight != '0);

        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            queued_nxt = '0;
            drop_nxt   = inflight_nxt;
        end else if (rsp && (drop != '0)) begin
            drop_nxt = drop - CW'(1);
        end

        if (redirect_valid) begin
            if (halt)                 state_nxt = HALT;
            else if (drop_nxt == '0)  state_nxt = RUN;
            else                      state_nxt = FLUSH;
        end else begin
            case (state)
                RUN:     if (halt) state_nxt = HALT;
                HALT:    if (!halt) state_nxt = (drop_nxt == '0) ? RUN : FLUSH;
                FLUSH:   if (drop_nxt == '0) state_nxt = halt ? HALT : RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_ADDR;
            inflight <= '0;
            queued   <= '0;
            drop     <= '0;
            af_wr    <= '0;
            af_rd    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            queued   <= queued_nxt;
            drop     <= drop_nxt;
            af_wr    <= af_wr + PW'(acc);
            af_rd    <= af_rd + PW'(rsp);
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
                q_wr     <= '0;
                q_rd     <= '0;
            end else begin
                if (acc) fetch_pc <= fetch_pc + 32'(INSN_BYTES);
                q_wr <= q_wr + PW'(push);
                q_rd <= q_rd + PW'(pop);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (acc) af_mem[af_wr] <= fetch_pc;
        if (push) begin
            q_addr[q_wr] <= af_mem[af_rd];
            q_data[q_wr] <= mem_rsp_data;
        end
    end
endmodule
